// File: rtl/prefix_pkg.sv
// Shared constants and types for the 64-bit parallel-prefix subtractor.
package prefix_pkg;

  localparam int WIDTH       = 64;
  localparam int LEVELS      = 6;
  // Prefix levels 1..SPLIT_LEVEL run before the S2 register, the rest after it.
  localparam int SPLIT_LEVEL = 3;

  // Generate/propagate pair carried through the prefix network.
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

endpackage

// File: rtl/prefix_gp_cell.sv
// Kogge-Stone black cell: merges a high group (hi) with the adjacent low group (lo).
module prefix_gp_cell
  import prefix_pkg::*;
(
  input  gp_t hi,
  input  gp_t lo,
  output gp_t o
);

  assign o.g = hi.g | (hi.p & lo.g);
  assign o.p = hi.p & lo.p;

endmodule

// File: rtl/prefix_sub64.sv
// Pipelined 64-bit subtractor diff = a - b - bin built as a + ~b + ~bin on a
// Kogge-Stone carry network. Four register slots: S1 (operands), S2 (prefix
// levels 1-3), S3 (prefix levels 4-6), output (diff/bout/flags).
//
// Handshake: a beat moves across an interface on a rising edge where
// valid && ready are both high. A source holds its beat (valid and data)
// until it is taken; ready never depends on valid. in_ready is a purely
// combinational function of out_ready and the stage valid bits.
//
// Optional feature macro: PREFIX_SUB_FLAGS_EN enables the zero/neg/ovf flags
// and the a[63]/b[63] sideband they need; without it the flags read 0.
module prefix_sub64
  import prefix_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  // ---------------------------------------------------------------------------
  // Stage occupancy and the combinational ready chain
  // ---------------------------------------------------------------------------
  logic s1_v, s2_v, s3_v;
  logic out_adv, s3_adv, s2_adv, s1_adv;

  assign out_adv  = !out_valid || out_ready;
  assign s3_adv   = !s3_v || out_adv;
  assign s2_adv   = !s2_v || s3_adv;
  assign s1_adv   = !s1_v || s2_adv;
  assign in_ready = s1_adv;

  // Valid bits shift forward whenever the receiving slot advances.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s3_v      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_adv)  s1_v      <= in_valid;
      if (s2_adv)  s2_v      <= s1_v;
      if (s3_adv)  s3_v      <= s2_v;
      if (out_adv) out_valid <= s3_v;
    end
  end

  // ---------------------------------------------------------------------------
  // S1: operands, inverted subtrahend and carry-in
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] s1_a, s1_nb;
  logic             s1_cin;

  // Capture a beat only when it is actually accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a   <= '0;
      s1_nb  <= '0;
      s1_cin <= 1'b0;
    end else if (in_valid && s1_adv) begin
      s1_a   <= a;
      s1_nb  <= ~b;
      s1_cin <= ~bin;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix levels 1-3 (spans 1, 2, 4) between S1 and S2
  // ---------------------------------------------------------------------------
  gp_t l0 [WIDTH];
  gp_t l1 [WIDTH];
  gp_t l2 [WIDTH];
  gp_t l3 [WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_lo_net
    assign l0[i] = '{g: s1_a[i] & s1_nb[i], p: s1_a[i] ^ s1_nb[i]};

    if (i >= 1) begin : g_l1_cell
      prefix_gp_cell u_cell (.hi(l0[i]), .lo(l0[i-1]), .o(l1[i]));
    end else begin : g_l1_pass
      assign l1[i] = l0[i];
    end

    if (i >= 2) begin : g_l2_cell
      prefix_gp_cell u_cell (.hi(l1[i]), .lo(l1[i-2]), .o(l2[i]));
    end else begin : g_l2_pass
      assign l2[i] = l1[i];
    end

    if (i >= 4) begin : g_l3_cell
      prefix_gp_cell u_cell (.hi(l2[i]), .lo(l2[i-4]), .o(l3[i]));
    end else begin : g_l3_pass
      assign l3[i] = l2[i];
    end
  end

  // ---------------------------------------------------------------------------
  // S2: partial group g/p, bitwise p and carry-in
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] s2_g, s2_p, s2_p0;
  logic             s2_cin;
`ifdef PREFIX_SUB_FLAGS_EN
  logic             s2_a63, s2_b63;
`endif

  // Load from S1 when S1 holds a beat and S2 is free to move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_g   <= '0;
      s2_p   <= '0;
      s2_p0  <= '0;
      s2_cin <= 1'b0;
`ifdef PREFIX_SUB_FLAGS_EN
      s2_a63 <= 1'b0;
      s2_b63 <= 1'b0;
`endif
    end else if (s1_v && s2_adv) begin
      for (int i = 0; i < WIDTH; i++) begin
        s2_g[i] <= l3[i].g;
        s2_p[i] <= l3[i].p;
      end
      s2_p0  <= s1_a ^ s1_nb;
      s2_cin <= s1_cin;
`ifdef PREFIX_SUB_FLAGS_EN
      s2_a63 <= s1_a[WIDTH-1];
      s2_b63 <= ~s1_nb[WIDTH-1];
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Prefix levels 4-6 (spans 8, 16, 32) between S2 and S3
  // ---------------------------------------------------------------------------
  gp_t m3 [WIDTH];
  gp_t m4 [WIDTH];
  gp_t m5 [WIDTH];
  gp_t m6 [WIDTH];

  for (genvar i = 0; i < WIDTH; i++) begin : g_hi_net
    assign m3[i] = '{g: s2_g[i], p: s2_p[i]};

    if (i >= 8) begin : g_l4_cell
      prefix_gp_cell u_cell (.hi(m3[i]), .lo(m3[i-8]), .o(m4[i]));
    end else begin : g_l4_pass
      assign m4[i] = m3[i];
    end

    if (i >= 16) begin : g_l5_cell
      prefix_gp_cell u_cell (.hi(m4[i]), .lo(m4[i-16]), .o(m5[i]));
    end else begin : g_l5_pass
      assign m5[i] = m4[i];
    end

    if (i >= 32) begin : g_l6_cell
      prefix_gp_cell u_cell (.hi(m5[i]), .lo(m5[i-32]), .o(m6[i]));
    end else begin : g_l6_pass
      assign m6[i] = m5[i];
    end
  end

  // ---------------------------------------------------------------------------
  // S3: full group G[i:0]/P[i:0], bitwise p and carry-in
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] s3_g, s3_p, s3_p0;
  logic             s3_cin;
`ifdef PREFIX_SUB_FLAGS_EN
  logic             s3_a63, s3_b63;
`endif

  // Load from S2 when S2 holds a beat and S3 is free to move.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_g   <= '0;
      s3_p   <= '0;
      s3_p0  <= '0;
      s3_cin <= 1'b0;
`ifdef PREFIX_SUB_FLAGS_EN
      s3_a63 <= 1'b0;
      s3_b63 <= 1'b0;
`endif
    end else if (s2_v && s3_adv) begin
      for (int i = 0; i < WIDTH; i++) begin
        s3_g[i] <= m6[i].g;
        s3_p[i] <= m6[i].p;
      end
      s3_p0  <= s2_p0;
      s3_cin <= s2_cin;
`ifdef PREFIX_SUB_FLAGS_EN
      s3_a63 <= s2_a63;
      s3_b63 <= s2_b63;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Carry fold-in and sum
  // ---------------------------------------------------------------------------
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] diff_c;
  logic             bout_c;

  // carry[i+1] = G[i:0] | P[i:0] & cin; the borrow is the inverted carry-out.
  always_comb begin
    carry    = '0;
    carry[0] = s3_cin;
    for (int i = 0; i < WIDTH; i++) begin
      carry[i+1] = s3_g[i] | (s3_p[i] & s3_cin);
    end
    diff_c = s3_p0 ^ carry[WIDTH-1:0];
    bout_c = ~carry[WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Output stage
  // ---------------------------------------------------------------------------
`ifdef PREFIX_SUB_FLAGS_EN
  logic zero_c, neg_c, ovf_c;
  assign zero_c = (diff_c == '0);
  assign neg_c  = diff_c[WIDTH-1];
  assign ovf_c  = (s3_a63 != s3_b63) && (diff_c[WIDTH-1] != s3_a63);
`else
  assign zero = 1'b0;
  assign neg  = 1'b0;
  assign ovf  = 1'b0;
`endif

  // Result registers hold their value while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff <= '0;
      bout <= 1'b0;
`ifdef PREFIX_SUB_FLAGS_EN
      zero <= 1'b0;
      neg  <= 1'b0;
      ovf  <= 1'b0;
`endif
    end else if (s3_v && out_adv) begin
      diff <= diff_c;
      bout <= bout_c;
`ifdef PREFIX_SUB_FLAGS_EN
      zero <= zero_c;
      neg  <= neg_c;
      ovf  <= ovf_c;
`endif
    end
  end

endmodule

// File: tb/tb_prefix_sub64.sv
// Self-checking bench for prefix_sub64. Expected results come from a plain
// arithmetic model of a - b - bin; a queue tracks beats in flight.
module tb_prefix_sub64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        bin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] diff;
  logic        bout, zero, neg, ovf;

  int checks = 0;
  int errors = 0;

  logic [67:0] exp_q[$];

  // snapshot of DUT pins taken 1 ns after each falling edge
  logic        s_acc, s_ret, s_in_ready, s_out_valid;
  logic [67:0] s_res;

  prefix_sub64 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .zero     (zero),
    .neg      (neg),
    .ovf      (ovf)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // {diff, bout, zero, neg, ovf}
  function automatic logic [67:0] ref_model(input logic [63:0] ra, input logic [63:0] rb,
                                            input logic rbin);
    logic [64:0] full;
    logic [63:0] d;
    logic        bo, z, n, o;
    full = {1'b0, ra} - {1'b0, rb} - {64'd0, rbin};
    d    = full[63:0];
    bo   = full[64];
`ifdef PREFIX_SUB_FLAGS_EN
    z = (d == 64'd0);
    n = d[63];
    o = (ra[63] != rb[63]) && (d[63] != ra[63]);
`else
    z = 1'b0;
    n = 1'b0;
    o = 1'b0;
`endif
    return {d, bo, z, n, o};
  endfunction

  // ---------------- driver tasks ----------------
  // Sample pins away from the edge, then move to the next falling edge.
  task automatic tick();
    #1;
    s_in_ready  = in_ready;
    s_out_valid = out_valid;
    s_acc       = in_valid && in_ready;
    s_ret       = out_valid && out_ready;
    s_res       = {diff, bout, zero, neg, ovf};
    @(negedge clk);
  endtask

  // Send one beat into an empty pipe and wait for its result.
  // lat = edges after the accepting edge until out_valid is seen (-1 on timeout).
  task automatic run_one(input logic [63:0] ta, input logic [63:0] tb, input logic tbin,
                         output logic [67:0] got, output int lat);
    bit accepted = 0;
    got       = '0;
    lat       = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a         = ta;
    b         = tb;
    bin       = tbin;
    for (int k = 0; k < 10 && !accepted; k++) begin
      tick();
      accepted = s_acc;
    end
    in_valid = 1'b0;
    if (accepted) begin
      for (int k = 1; k <= 10; k++) begin
        tick();
        if (s_out_valid) begin
          lat = k - 1;
          got = s_res;
          break;
        end
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    checks++;
    if ({out_valid, diff, bout, zero, neg, ovf} !== 69'd0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%0b diff=%h bout=%0b z/n/o=%0b%0b%0b want all 0",
               out_valid, diff, bout, zero, neg, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready got %0b want 1", s_in_ready);
    end
  endtask

  task automatic test_simple();
    logic [67:0] got;
    int lat;
    run_one(64'd5, 64'd3, 1'b0, got, lat);
    checks++;
    if (got[67:4] !== 64'd2 || got[3] !== 1'b0) begin
      errors++;
      $display("FAIL simple_sub got diff=%h bout=%0b want diff=2 bout=0", got[67:4], got[3]);
    end
    checks++;
    if (lat !== 3) begin
      errors++;
      $display("FAIL simple_latency got %0d want 3", lat);
    end
  endtask

  task automatic test_underflow();
    logic [67:0] got;
    int lat;
    run_one(64'd0, 64'd1, 1'b0, got, lat);
    checks++;
    if (got !== ref_model(64'd0, 64'd1, 1'b0) || got[67:4] !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      errors++;
      $display("FAIL underflow got %h want %h", got, ref_model(64'd0, 64'd1, 1'b0));
    end
  endtask

  task automatic test_overflow();
    logic [67:0] got;
    int lat;
    run_one(64'h8000_0000_0000_0000, 64'd1, 1'b0, got, lat);
    checks++;
    if (got !== ref_model(64'h8000_0000_0000_0000, 64'd1, 1'b0) ||
        got[67:4] !== 64'h7FFF_FFFF_FFFF_FFFF || got[3] !== 1'b0) begin
      errors++;
      $display("FAIL signed_ovf got %h want %h", got,
               ref_model(64'h8000_0000_0000_0000, 64'd1, 1'b0));
    end
    run_one(64'h1234, 64'h1234, 1'b1, got, lat);
    checks++;
    if (got !== ref_model(64'h1234, 64'h1234, 1'b1) ||
        got[67:4] !== 64'hFFFF_FFFF_FFFF_FFFF || got[3] !== 1'b1) begin
      errors++;
      $display("FAIL equal_bin got %h want %h", got, ref_model(64'h1234, 64'h1234, 1'b1));
    end
  endtask

  task automatic test_backpressure();
    int idx = 0;
    int n_ret = 0;
    logic [63:0] res [16];
    out_ready = 1'b0;
    b   = 64'd1;
    bin = 1'b0;
    for (int t = 0; t < 8; t++) begin
      in_valid = (idx < 6);
      a = 64'd10 + 64'(idx);
      tick();
      if (s_acc) idx++;
    end
    checks++;
    if (idx !== 4 || s_in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_fill got accepts=%0d in_ready=%0b want 4 and 0", idx, s_in_ready);
    end
    out_ready = 1'b1;
    for (int t = 0; t < 15; t++) begin
      in_valid = (idx < 6);
      a = 64'd10 + 64'(idx);
      tick();
      if (t == 0) begin
        checks++;
        if (s_in_ready !== 1'b1) begin
          errors++;
          $display("FAIL bp_ready_return got %0b want 1", s_in_ready);
        end
      end
      if (s_acc) idx++;
      if (s_ret) begin
        if (n_ret < 16) res[n_ret] = s_res[67:4];
        n_ret++;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (n_ret !== 6 || idx !== 6) begin
      errors++;
      $display("FAIL bp_count got retired=%0d accepted=%0d want 6 and 6", n_ret, idx);
    end
    for (int k = 0; k < 6 && k < n_ret; k++) begin
      checks++;
      if (res[k] !== 64'd9 + 64'(k)) begin
        errors++;
        $display("FAIL bp_order[%0d] got %0d want %0d", k, res[k], 9 + k);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [67:0] got;
    int lat;
    int idx = 0;
    out_ready = 1'b0;
    b   = 64'd1;
    bin = 1'b0;
    for (int t = 0; t < 6; t++) begin
      in_valid = (idx < 4);
      a = 64'd100 + 64'(idx);
      tick();
      if (s_acc) idx++;
    end
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || diff !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_flush got valid=%0b diff=%h want 0 and 0", out_valid, diff);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++;
    if (s_out_valid !== 1'b0 || s_in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_idle got valid=%0b in_ready=%0b want 0 and 1",
               s_out_valid, s_in_ready);
    end
    run_one(64'd7, 64'd7, 1'b0, got, lat);
    checks++;
    if (got !== ref_model(64'd7, 64'd7, 1'b0) || lat !== 3) begin
      errors++;
      $display("FAIL reset_mid_after got %h lat=%0d want %h lat=3", got, lat,
               ref_model(64'd7, 64'd7, 1'b0));
    end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    int sent = 0;
    int got_n = 0;
    int cyc = 0;
    logic prev_stall = 1'b0;
    logic [67:0] prev_res = '0;
    logic [67:0] exp;
    exp_q.delete();
    in_valid = 1'b0;
    while (got_n < N && cyc < 60000) begin
      if (!in_valid && sent < N && $urandom_range(0, 3) != 0) begin
        in_valid = 1'b1;
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        bin = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 7))
          0: b = a;
          1: a = 64'd0;
          2: b = '1;
          3: a = {1'b1, a[62:0]};
          default: ;
        endcase
      end
      out_ready = ($urandom_range(0, 99) < 70);
      tick();
      cyc++;
      if (prev_stall) begin
        checks++;
        if (s_out_valid !== 1'b1 || s_res !== prev_res) begin
          errors++;
          $display("FAIL rand_stall_hold got valid=%0b res=%h want 1 res=%h",
                   s_out_valid, s_res, prev_res);
        end
      end
      prev_stall = s_out_valid && !s_ret;
      prev_res   = s_res;
      if (s_ret) begin
        got_n++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand_spurious got %h want no result", s_res);
        end else begin
          exp = exp_q.pop_front();
          if (s_res !== exp) begin
            errors++;
            $display("FAIL rand_result got %h want %h", s_res, exp);
          end
        end
      end
      if (s_acc) begin
        exp_q.push_back(ref_model(a, b, bin));
        sent++;
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got_n !== N || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL rand_complete got retired=%0d pending=%0d want %0d and 0",
               got_n, exp_q.size(), N);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_simple();
    test_underflow();
    test_overflow();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
